// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter.
// Mode, direction and default-width values used by the counter and its bench.
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: passes every (ps_div+1)-th enabled cycle as a tick.
// Ports: clk, reset (async, active-low), clr, en, ps_div, tick.
// Only built with COUNTER_PRESCALE_EN defined.
`ifdef COUNTER_PRESCALE_EN
module counter_prescaler #(
    parameter int PS_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    input  logic [PS_W-1:0] ps_div,
    output logic            tick
);

    logic [PS_W-1:0] cnt;

    // Combinational so the main counter steps on this same en cycle.
    assign tick = en && (cnt == ps_div);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/updown_mod_counter.sv
// Up/down counter with inclusive limit, wrap/saturate, step, tc and ovf.
// Ports: clk, reset (async low), load/d, en, up, sat, limit, clr_ovf
//        -> q, tc (boundary pulse), ovf (sticky). Option: COUNTER_PRESCALE_EN
//        adds PS_W and ps_div to divide the enable.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int             N       = CNT_W_DEF,
    parameter int             STEP    = 1,
    parameter logic [N-1:0]   RST_VAL = '0
`ifdef COUNTER_PRESCALE_EN
    ,
    parameter int             PS_W    = 8
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [N-1:0]    d,
    input  logic            en,
    input  logic            up,
    input  logic            sat,
    input  logic [N-1:0]    limit,
    input  logic            clr_ovf,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PS_W-1:0] ps_div,
`endif
    output logic [N-1:0]    q,
    output logic            tc,
    output logic            ovf
);

    localparam logic [N:0]   STEP_X = (N+1)'(STEP);
    localparam logic [N-1:0] STEP_N = N'(STEP);

    logic         step;
    logic [N:0]   q_x;
    logic [N:0]   lim_x;
    logic [N:0]   lim1;
    logic [N:0]   sum;
    logic [N-1:0] wrap_up;
    logic [N-1:0] wrap_dn;
    logic [N-1:0] d_clamp;
    logic [N-1:0] q_nxt;
    logic         bnd;

`ifdef COUNTER_PRESCALE_EN
    logic tick;

    counter_prescaler #(
        .PS_W   (PS_W)
    ) u_ps (
        .clk    (clk),
        .reset  (reset),
        .clr    (load),
        .en     (en),
        .ps_div (ps_div),
        .tick   (tick)
    );

    assign step = tick;
`else
    assign step = en;
`endif

    // All boundary arithmetic at N+1 bits so no carry is lost.
    assign q_x     = {1'b0, q};
    assign lim_x   = {1'b0, limit};
    assign lim1    = lim_x + 1'b1;
    assign sum     = q_x + STEP_X;
    assign wrap_up = N'(sum - lim1);
    assign wrap_dn = N'(q_x + lim1 - STEP_X);
    assign d_clamp = (d > limit) ? limit : d;

    always_comb begin
        q_nxt = q;
        bnd   = 1'b0;
        if (q > limit) begin
            // Limit dropped below q: snap back into range.
            bnd   = 1'b1;
            q_nxt = (up == DIR_UP && sat == MODE_WRAP) ? '0 : limit;
        end else if (up == DIR_UP) begin
            if (sum <= lim_x) begin
                q_nxt = sum[N-1:0];
            end else begin
                bnd   = 1'b1;
                q_nxt = (sat == MODE_SAT) ? limit : wrap_up;
            end
        end else begin
            if (q_x >= STEP_X) begin
                q_nxt = q - STEP_N;
            end else begin
                bnd   = 1'b1;
                q_nxt = (sat == MODE_SAT) ? '0 : wrap_dn;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q  <= RST_VAL;
            tc <= 1'b0;
        end else if (load) begin
            q  <= d_clamp;
            tc <= 1'b0;
        end else if (step) begin
            q  <= q_nxt;
            tc <= bnd;
        end else begin
            tc <= 1'b0;
        end
    end

    // Set beats clear when both happen on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (!load && step && bnd) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter (STEP=1 and STEP=3 instances).
// Prescale scenario runs only with COUNTER_PRESCALE_EN defined.
module tb_updown_mod_counter;

    typedef struct {
        logic        ld;
        logic [15:0] d;
        logic        en;
        logic        up;
        logic        sat;
        logic [15:0] lim;
        logic        clr;
    } stim_t;

    typedef struct {
        logic [15:0] q;
        logic        tc;
        logic        ovf;
        string       nm;
    } exp_t;

    stim_t stq[$];
    exp_t  sb[$];
    stim_t s;
    exp_t  e;

    int total = 0;
    int bad   = 0;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        load    = 1'b0;
    logic [15:0] d       = '0;
    logic        en      = 1'b0;
    logic        up      = 1'b1;
    logic        sat     = 1'b0;
    logic [15:0] limit   = 16'hFFFF;
    logic        clr_ovf = 1'b0;
`ifdef COUNTER_PRESCALE_EN
    logic [7:0]  ps_div  = 8'd0;
`endif

    logic [15:0] q1, q3;
    logic        tc1, tc3, ovf1, ovf3;

    always #5 clk = ~clk;

    updown_mod_counter #(.N(16), .STEP(1)) u1 (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .d       (d),
        .en      (en),
        .up      (up),
        .sat     (sat),
        .limit   (limit),
        .clr_ovf (clr_ovf),
`ifdef COUNTER_PRESCALE_EN
        .ps_div  (ps_div),
`endif
        .q       (q1),
        .tc      (tc1),
        .ovf     (ovf1)
    );

    updown_mod_counter #(.N(16), .STEP(3)) u3 (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .d       (d),
        .en      (en),
        .up      (up),
        .sat     (sat),
        .limit   (limit),
        .clr_ovf (clr_ovf),
`ifdef COUNTER_PRESCALE_EN
        .ps_div  (ps_div),
`endif
        .q       (q3),
        .tc      (tc3),
        .ovf     (ovf3)
    );

    task automatic add(input logic ld, input logic [15:0] dv,
                       input logic ev, input logic uv,
                       input logic sv, input logic [15:0] lv,
                       input logic cv, input logic [15:0] eq,
                       input logic et, input logic eo,
                       input string nm);
        stim_t st;
        exp_t  ex;
        st.ld = ld; st.d = dv; st.en = ev; st.up = uv;
        st.sat = sv; st.lim = lv; st.clr = cv;
        ex.q = eq; ex.tc = et; ex.ovf = eo; ex.nm = nm;
        stq.push_back(st);
        sb.push_back(ex);
    endtask

    task automatic apply(input stim_t st);
        load = st.ld; d = st.d; en = st.en; up = st.up;
        sat = st.sat; limit = st.lim; clr_ovf = st.clr;
    endtask

    task automatic idle();
        load = 1'b0; en = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        add(0, 0, 0, 1, 0, 16'hFFFF, 0, 16'h0000, 0, 0, "rst_hold");
        s = stq.pop_front();
        e = sb.pop_front();
        total++;
        if ({q1, tc1, ovf1} !== {e.q, e.tc, e.ovf}) begin
            bad++;
            $display("FAIL %s: got q=%h tc=%b ovf=%b want q=%h tc=%b ovf=%b",
                     e.nm, q1, tc1, ovf1, e.q, e.tc, e.ovf);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        add(1, 16'h1234, 0, 1, 0, 16'hFFFF, 0, 16'h1234, 0, 0, "load");
        add(0, 0, 1, 1, 0, 16'hFFFF, 0, 16'h1235, 0, 0, "inc1");
        add(0, 0, 1, 1, 0, 16'hFFFF, 0, 16'h1236, 0, 0, "inc2");
        while (stq.size() > 0) begin
            s = stq.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({q1, tc1, ovf1} !== {e.q, e.tc, e.ovf}) begin
                bad++;
                $display("FAIL %s: got q=%h tc=%b ovf=%b want q=%h tc=%b ovf=%b",
                         e.nm, q1, tc1, ovf1, e.q, e.tc, e.ovf);
            end
        end
        reset = 1'b0;
        add(0, 0, 1, 1, 0, 16'hFFFF, 0, 16'h0000, 0, 0, "rst_async");
        #1;
        s = stq.pop_front();
        e = sb.pop_front();
        total++;
        if ({q1, tc1, ovf1} !== {e.q, e.tc, e.ovf}) begin
            bad++;
            $display("FAIL %s: got q=%h tc=%b ovf=%b want q=%h tc=%b ovf=%b",
                     e.nm, q1, tc1, ovf1, e.q, e.tc, e.ovf);
        end
        idle();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_up_wrap();
        logic [15:0] mq;
        logic        mo;
        add(1, 0, 0, 1, 0, 9, 1, 0, 0, 0, "wrap_load");
        mq = 0;
        mo = 0;
        for (int i = 1; i <= 11; i++) begin
            mo = mo | (mq == 9);
            add(0, 0, 1, 1, 0, 9, 0, (mq == 9) ? 16'd0 : mq + 16'd1,
                mq == 9, mo, $sformatf("wrap_%0d", i));
            mq = (mq == 9) ? 16'd0 : mq + 16'd1;
        end
        add(0, 0, 0, 1, 0, 9, 0, mq, 0, mo, "wrap_hold");
        while (stq.size() > 0) begin
            s = stq.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({q1, tc1, ovf1} !== {e.q, e.tc, e.ovf}) begin
                bad++;
                $display("FAIL %s: got q=%0d tc=%b ovf=%b want q=%0d tc=%b ovf=%b",
                         e.nm, q1, tc1, ovf1, e.q, e.tc, e.ovf);
            end
        end
        idle();
    endtask

    task automatic test_down_sat();
        add(1, 2, 0, 0, 1, 9, 1, 2, 0, 0, "dsat_load");
        add(0, 0, 1, 0, 1, 9, 0, 1, 0, 0, "dsat_1");
        add(0, 0, 1, 0, 1, 9, 0, 0, 0, 0, "dsat_0");
        add(0, 0, 1, 0, 1, 9, 0, 0, 1, 1, "dsat_bnd");
        add(0, 0, 1, 0, 1, 9, 1, 0, 1, 1, "dsat_setwins");
        add(0, 0, 0, 0, 1, 9, 1, 0, 0, 0, "dsat_clr");
        while (stq.size() > 0) begin
            s = stq.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({q1, tc1, ovf1} !== {e.q, e.tc, e.ovf}) begin
                bad++;
                $display("FAIL %s: got q=%0d tc=%b ovf=%b want q=%0d tc=%b ovf=%b",
                         e.nm, q1, tc1, ovf1, e.q, e.tc, e.ovf);
            end
        end
        idle();
    endtask

    task automatic test_step3();
        add(1, 9,  0, 1, 0, 10, 1, 9,  0, 0, "s3_load");
        add(0, 0,  1, 1, 0, 10, 0, 1,  1, 1, "s3_upwrap");
        add(0, 0,  1, 0, 0, 10, 0, 9,  1, 1, "s3_dnwrap");
        add(1, 20, 0, 0, 0, 10, 0, 10, 0, 1, "s3_clamp");
        add(0, 0,  1, 0, 0, 10, 0, 7,  0, 1, "s3_dn");
        add(0, 0,  1, 1, 1, 10, 1, 10, 0, 0, "s3_upexact");
        add(0, 0,  1, 1, 1, 10, 0, 10, 1, 1, "s3_upsat");
        while (stq.size() > 0) begin
            s = stq.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({q3, tc3, ovf3} !== {e.q, e.tc, e.ovf}) begin
                bad++;
                $display("FAIL %s: got q=%0d tc=%b ovf=%b want q=%0d tc=%b ovf=%b",
                         e.nm, q3, tc3, ovf3, e.q, e.tc, e.ovf);
            end
        end
        idle();
    endtask

    task automatic test_limit();
        add(1, 50, 0, 1, 0, 16'hFFFF, 1, 50, 0, 0, "lim_load");
        add(0, 0,  0, 1, 0, 20,       0, 50, 0, 0, "lim_hold");
        add(0, 0,  1, 1, 0, 20,       0, 0,  1, 1, "lim_upwrap");
        add(1, 50, 0, 1, 0, 16'hFFFF, 1, 50, 0, 0, "lim_reload");
        add(0, 0,  1, 0, 0, 20,       0, 20, 1, 1, "lim_dn");
        add(1, 5,  0, 1, 0, 0,        1, 0,  0, 0, "lim0_load");
        add(0, 0,  1, 1, 0, 0,        0, 0,  1, 1, "lim0_up");
        add(0, 0,  1, 0, 1, 0,        0, 0,  1, 1, "lim0_dn");
        while (stq.size() > 0) begin
            s = stq.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({q1, tc1, ovf1} !== {e.q, e.tc, e.ovf}) begin
                bad++;
                $display("FAIL %s: got q=%0d tc=%b ovf=%b want q=%0d tc=%b ovf=%b",
                         e.nm, q1, tc1, ovf1, e.q, e.tc, e.ovf);
            end
        end
        idle();
    endtask

`ifdef COUNTER_PRESCALE_EN
    task automatic test_prescale();
        ps_div = 8'd3;
        add(1, 0, 0, 1, 0, 16'hFFFF, 1, 0, 0, 0, "ps_load");
        for (int i = 1; i <= 12; i++) begin
            add(0, 0, 1, 1, 0, 16'hFFFF, 0, 16'(i / 4), 0, 0,
                $sformatf("ps_%0d", i));
        end
        add(0, 0, 1, 1, 0, 16'hFFFF, 0, 3, 0, 0, "ps_pre1");
        add(0, 0, 1, 1, 0, 16'hFFFF, 0, 3, 0, 0, "ps_pre2");
        add(1, 3, 0, 1, 0, 16'hFFFF, 0, 3, 0, 0, "ps_reload");
        add(0, 0, 1, 1, 0, 16'hFFFF, 0, 3, 0, 0, "ps_r1");
        add(0, 0, 1, 1, 0, 16'hFFFF, 0, 3, 0, 0, "ps_r2");
        add(0, 0, 1, 1, 0, 16'hFFFF, 0, 3, 0, 0, "ps_r3");
        add(0, 0, 1, 1, 0, 16'hFFFF, 0, 4, 0, 0, "ps_r4");
        while (stq.size() > 0) begin
            s = stq.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({q1, tc1, ovf1} !== {e.q, e.tc, e.ovf}) begin
                bad++;
                $display("FAIL %s: got q=%0d tc=%b ovf=%b want q=%0d tc=%b ovf=%b",
                         e.nm, q1, tc1, ovf1, e.q, e.tc, e.ovf);
            end
        end
        idle();
        ps_div = 8'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_step3();
        test_limit();
`ifdef COUNTER_PRESCALE_EN
        test_prescale();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the team's 16-bit load/increment counter.
- Adds up/down counting, a programmable inclusive upper limit, selectable wrap or saturate mode, a configurable step, a terminal-count pulse and a sticky overflow flag.
- Used as a timebase and event counter in the lab designs.
- Single clock domain; registered outputs.

Parameters:
- N, 16, counter width in bits.
- STEP, 1, increment/decrement amount per enabled cycle; legal range 1..2^N-1.
- RST_VAL, 0, value of q after reset; must be ≤ limit in use.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  synchronous load of d.
- d  in  N  load value.
- en  in  1  count enable.
- up  in  1  direction: 1 = count up, 0 = count down.
- sat  in  1  mode: 1 = saturate, 0 = wrap.
- limit  in  N  inclusive upper bound; legal range is [0, limit].
- clr_ovf  in  1  synchronous clear of ovf.
- q  out  N  count value.
- tc  out  1  terminal-count pulse, one cycle wide.
- ovf  out  1  sticky boundary-event flag.

Behaviour:
- Reset (reset=0, asynchronous): q=RST_VAL, tc=0, ovf=0. Outputs are held while reset is low. Release is synchronous to the clk edge.
- Latency: every update is visible on q one cycle after the sampling edge. tc is registered and coincides with the q update that caused it.
- Priority per edge: load > en > hold.
- load=1: q = min(d, limit); tc=0. With COUNTER_PRESCALE_EN, the prescaler is also cleared.
- en=1, up=1: compute q+STEP at N+1 bits.
  - Result ≤ limit: q = q+STEP.
  - Otherwise, boundary event: wrap gives q = q+STEP-(limit+1); sat gives q = limit.
- en=1, up=0:
  - q ≥ STEP: q = q-STEP.
  - Otherwise, boundary event: wrap gives q = q+(limit+1)-STEP, computed at N+1 bits; sat gives q = 0.
- Wrap results are in range only when STEP ≤ limit+1. Configurations outside this are illegal; q is undefined-but-safe.
- Boundary event: tc=1 for exactly one cycle and ovf is set.
  - Saturate mode, already at the bound: each further enabled step counts as a boundary event. tc pulses each cycle and q is unchanged.
- tc=0 on every cycle without a boundary event, including load, hold and en=0.
- Out-of-range q (q > limit, e.g. limit lowered while counting), on an enabled step: q = 0 if up and wrap, otherwise q = limit; counts as a boundary event.
- While en=0, q holds regardless of limit changes.
- ovf: sticky, cleared by clr_ovf. A boundary event and clr_ovf in the same cycle leaves ovf=1 (set wins).
- limit=0: q is held at 0. Every enabled step is a boundary event.
- Changes to up, sat or limit take effect on the next enabled edge. There is no internal state beyond q, tc, ovf and the optional prescaler.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- With macro defined:
  - Adds parameter PS_W (default 8) and input port ps_div [PS_W-1:0].
  - An internal prescale counter advances on each en=1 cycle.
  - The main counter steps only on the en cycle where the prescale count equals ps_div; the prescale counter then returns to 0.
  - ps_div=0 gives a step on every en cycle.
  - Prescale count resets to 0 on reset and on load.
  - en=0 freezes the prescale count.
- Without macro: no ps_div port and no PS_W parameter; the counter steps on every en=1 cycle.

Decomposition:
- Package counter_pkg:
  - Mode constants MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - Direction constants DIR_DOWN=1'b0, DIR_UP=1'b1.
  - Default width constant CNT_W_DEF=16.
- Sub-module counter_prescaler (only instantiated under COUNTER_PRESCALE_EN).
  - Ports: clk, reset, clr, en, ps_div, tick.
  - tick is combinational from the current count and en.
- Next-state arithmetic stays inline in updown_mod_counter.

Test Plan:
- Reset/load: reset=0 then released, limit=16'hFFFF, load d=16'h1234 → q=16'h1234 next edge, tc=0, ovf=0. Then assert reset mid-count → q=0 immediately, without waiting for a clock edge.
- Up wrap: limit=9, STEP=1, sat=0, up=1, en=1 from q=0 → q counts 0..9, 0. tc is high only on the 9→0 cycle; ovf=1 afterwards.
- Down saturate: limit=9, sat=1, up=0 from q=2 → q=1, 0, 0, 0. tc pulses on each at-zero enabled step; clr_ovf together with a boundary event leaves ovf=1.
- Step/limit edge: STEP=3 build, limit=10, sat=0.
  - Up from q=9 → q=1.
  - Down from q=1 → q=9.
  - Load d=20 → q=10 (clamped).
- Limit lowered: q=50, limit changed to 20, en=1 up=1 sat=0 → q=0 and tc=1. With en=0 instead, q holds at 50.
- Prescale (COUNTER_PRESCALE_EN, ps_div=3): en held high for 12 cycles from q=0 → q=3, steps on every 4th en cycle. A load mid-sequence restarts the 4-cycle spacing.
